// File: rtl/reg_demux_wb_if.sv
// Write-request handshake between a producer and the register-bank write demux.
// Carries the destination slot, the data word and the valid/ready pair.
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif

interface reg_demux_wb_if #(
    parameter int SIGNAL_WIDTH   = `REG_WIDTH,
    parameter int SELECTOR_WIDTH = 4
);
    logic                      in_valid;
    logic [SELECTOR_WIDTH-1:0] in_sel;
    logic [SIGNAL_WIDTH-1:0]   in_data;
    logic                      in_ready;

    modport master (output in_valid, output in_sel, output in_data, input in_ready);
    modport slave  (input in_valid, input in_sel, input in_data, output in_ready);
endinterface

// File: rtl/reg_demux_wb.sv
// Write-back demux for the 16-entry register bank: a 2-deep request FIFO
// drains one write per cycle into held slots and pulses a one-hot strobe.
//
// state | meaning
// EMPTY | no buffered request, nothing to drain
// ONE   | one request buffered, drains next edge unless hold
// FULL  | two requests buffered, in_ready low
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif

module reg_demux_wb #(
    parameter int SIGNAL_WIDTH   = `REG_WIDTH,
    parameter int SELECTOR_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    reg_demux_wb_if.slave              wb,
    input  logic                       hold,
    output logic [16*SIGNAL_WIDTH-1:0] bank_flat,
    output logic [15:0]                wr_strobe,
    output logic [1:0]                 pending
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fill_t;

    fill_t                     state;
    logic                      head;
    logic                      tail;
    logic [SELECTOR_WIDTH-1:0] fifo_sel  [2];
    logic [SIGNAL_WIDTH-1:0]   fifo_data [2];
    logic [SIGNAL_WIDTH-1:0]   bank      [16];
    logic                      accept;
    logic                      drain;

    // No pass-through when full: readiness depends on the registered count only.
    assign wb.in_ready = (state != FULL);
    assign accept      = wb.in_valid && wb.in_ready;
    assign drain       = (state != EMPTY) && !hold;
    assign pending     = state;

    for (genvar i = 0; i < 16; i++) begin : g_flat
        assign bank_flat[i*SIGNAL_WIDTH +: SIGNAL_WIDTH] = bank[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            head      <= 1'b0;
            tail      <= 1'b0;
            wr_strobe <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_sel[i]  <= '0;
                fifo_data[i] <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                bank[i] <= '0;
            end
        end else begin
            wr_strobe <= '0;
            if (accept) begin
                fifo_sel[tail]  <= wb.in_sel;
                fifo_data[tail] <= wb.in_data;
                tail            <= ~tail;
            end
            // Drain reads the pre-edge head, so a request accepted now waits a cycle.
            if (drain) begin
                bank[fifo_sel[head]] <= fifo_data[head];
                wr_strobe            <= 16'h0001 << fifo_sel[head];
                head                 <= ~head;
            end
            case ({accept, drain})
                2'b10:   state <= (state == EMPTY) ? ONE : FULL;
                2'b01:   state <= (state == FULL) ? ONE : EMPTY;
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_demux_wb.sv
// Self-checking bench for reg_demux_wb: table-driven corner vectors plus a
// scoreboard model that predicts every commit, strobe and the full bank.
module tb_reg_demux_wb;
    localparam int W = 8;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            hold  = 1'b0;
    logic [16*W-1:0] bank_flat;
    logic [15:0]     wr_strobe;
    logic [1:0]      pending;

    reg_demux_wb_if #(.SIGNAL_WIDTH(W), .SELECTOR_WIDTH(4)) wbif ();

    reg_demux_wb #(.SIGNAL_WIDTH(W), .SELECTOR_WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb        (wbif),
        .hold      (hold),
        .bank_flat (bank_flat),
        .wr_strobe (wr_strobe),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard model: queue of accepted requests, expected commit per edge.
    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] data;
    } req_t;

    req_t        mq[$];
    int          mcount;
    logic [7:0]  mbank [16];
    logic        exp_valid;
    req_t        exp_req;
    logic        acc_m;
    logic        dr_m;
    logic        chk_en = 1'b0;
    logic [127:0] mflat;
    logic [15:0]  mstrobe;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mcount    = 0;
            exp_valid = 1'b0;
            exp_req   = '0;
            for (int i = 0; i < 16; i++) mbank[i] = 8'h00;
        end else begin
            acc_m     = wbif.in_valid && (mcount != 2);
            dr_m      = (mcount != 0) && !hold;
            exp_valid = dr_m;
            if (dr_m) begin
                exp_req = mq.pop_front();
                mbank[exp_req.sel] = exp_req.data;
            end
            if (acc_m) mq.push_back({wbif.in_sel, wbif.in_data});
            mcount = mcount + int'(acc_m) - int'(dr_m);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 16; i++) mflat[i*8 +: 8] = mbank[i];
            mstrobe = exp_valid ? (16'h0001 << exp_req.sel) : 16'h0000;
            check("sb_pending", 128'(pending), 128'(mcount));
            check("sb_in_ready", 128'(wbif.in_ready), 128'(mcount != 2));
            check("sb_wr_strobe", 128'(wr_strobe), 128'(mstrobe));
            check("sb_bank", bank_flat, mflat);
        end
    end

    task automatic drive(input logic v, input logic [3:0] s, input logic [7:0] d, input logic h);
        wbif.in_valid = v;
        wbif.in_sel   = s;
        wbif.in_data  = d;
        hold          = h;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] slot(input logic [3:0] i);
        logic [127:0] f;
        f = bank_flat;
        return f[i*8 +: 8];
    endfunction

    typedef struct {
        logic       v;
        logic [3:0] sel;
        logic [7:0] data;
        logic       h;
        logic [1:0] p;
        logic       r;
        logic [15:0] s;
        logic [3:0] cs;
        logic [7:0] cd;
    } vec_t;

    vec_t tbl[18];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          v     sel    data   h     p     r     strobe    cs     cd
        tbl[0]  = '{1'b1, 4'd5,  8'hA7, 1'b0, 2'd1, 1'b1, 16'h0000, 4'd5,  8'h00};
        tbl[1]  = '{1'b0, 4'd0,  8'h00, 1'b0, 2'd0, 1'b1, 16'h0020, 4'd5,  8'hA7};
        tbl[2]  = '{1'b0, 4'd0,  8'h00, 1'b0, 2'd0, 1'b1, 16'h0000, 4'd5,  8'hA7};
        tbl[3]  = '{1'b1, 4'd3,  8'h11, 1'b1, 2'd1, 1'b1, 16'h0000, 4'd3,  8'h00};
        tbl[4]  = '{1'b1, 4'd3,  8'h22, 1'b1, 2'd2, 1'b0, 16'h0000, 4'd3,  8'h00};
        tbl[5]  = '{1'b1, 4'd3,  8'h33, 1'b1, 2'd2, 1'b0, 16'h0000, 4'd3,  8'h00};
        tbl[6]  = '{1'b0, 4'd0,  8'h00, 1'b0, 2'd1, 1'b1, 16'h0008, 4'd3,  8'h11};
        tbl[7]  = '{1'b0, 4'd0,  8'h00, 1'b0, 2'd0, 1'b1, 16'h0008, 4'd3,  8'h22};
        tbl[8]  = '{1'b0, 4'd0,  8'h00, 1'b0, 2'd0, 1'b1, 16'h0000, 4'd3,  8'h22};
        tbl[9]  = '{1'b1, 4'd9,  8'hFF, 1'b0, 2'd1, 1'b1, 16'h0000, 4'd9,  8'h00};
        tbl[10] = '{1'b1, 4'd9,  8'h00, 1'b0, 2'd1, 1'b1, 16'h0200, 4'd9,  8'hFF};
        tbl[11] = '{1'b0, 4'd0,  8'h00, 1'b0, 2'd0, 1'b1, 16'h0200, 4'd9,  8'h00};
        tbl[12] = '{1'b1, 4'd1,  8'h44, 1'b0, 2'd1, 1'b1, 16'h0000, 4'd1,  8'h00};
        tbl[13] = '{1'b1, 4'd15, 8'h5A, 1'b0, 2'd1, 1'b1, 16'h0002, 4'd1,  8'h44};
        tbl[14] = '{1'b0, 4'd0,  8'h00, 1'b0, 2'd0, 1'b1, 16'h8000, 4'd15, 8'h5A};
        tbl[15] = '{1'b1, 4'd2,  8'h77, 1'b1, 2'd1, 1'b1, 16'h0000, 4'd2,  8'h00};
        tbl[16] = '{1'b0, 4'd0,  8'h00, 1'b1, 2'd1, 1'b1, 16'h0000, 4'd2,  8'h00};
        tbl[17] = '{1'b0, 4'd0,  8'h00, 1'b0, 2'd0, 1'b1, 16'h0004, 4'd2,  8'h77};

        drive(1'b0, 4'd0, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_bank", bank_flat, 128'h0);
        check("rst_strobe", 128'(wr_strobe), 128'h0);
        check("rst_pending", 128'(pending), 128'h0);
        check("rst_ready", 128'(wbif.in_ready), 128'h1);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].v, tbl[i].sel, tbl[i].data, tbl[i].h);
            step();
            check($sformatf("vec%0d_pending", i), 128'(pending), 128'(tbl[i].p));
            check($sformatf("vec%0d_ready", i), 128'(wbif.in_ready), 128'(tbl[i].r));
            check($sformatf("vec%0d_strobe", i), 128'(wr_strobe), 128'(tbl[i].s));
            check($sformatf("vec%0d_slot", i), 128'(slot(tbl[i].cs)), 128'(tbl[i].cd));
        end

        // Sustained stream: one write per cycle, pending pinned at 1.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'(i), 8'(8'h10 + i), 1'b0);
            step();
            check($sformatf("stream%0d_pending", i), 128'(pending), 128'h1);
        end
        drive(1'b0, 4'd0, 8'h00, 1'b0);
        step();
        check("stream_last_strobe", 128'(wr_strobe), 128'h8000);
        step();
        for (int i = 0; i < 16; i++) begin
            check($sformatf("stream_slot%0d", i), 128'(slot(4'(i))), 128'(8'h10 + i));
        end

        // Reset mid-stream with two requests buffered.
        drive(1'b1, 4'd3, 8'hC1, 1'b1);
        step();
        drive(1'b1, 4'd4, 8'hC2, 1'b1);
        step();
        check("pre_rst_pending", 128'(pending), 128'h2);
        drive(1'b0, 4'd0, 8'h00, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_bank", bank_flat, 128'h0);
        check("async_rst_strobe", 128'(wr_strobe), 128'h0);
        check("async_rst_pending", 128'(pending), 128'h0);
        check("async_rst_ready", 128'(wbif.in_ready), 128'h1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("post_rst%0d_strobe", i), 128'(wr_strobe), 128'h0);
            check($sformatf("post_rst%0d_pending", i), 128'(pending), 128'h0);
        end
        drive(1'b1, 4'd6, 8'h66, 1'b0);
        step();
        drive(1'b0, 4'd0, 8'h00, 1'b0);
        step();
        check("post_rst_write_strobe", 128'(wr_strobe), 128'h0040);
        check("post_rst_write_slot", 128'(slot(4'd6)), 128'h66);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/reg_demux_wb.md
# reg_demux_wb

Write-back demultiplexer for the 16-entry register bank: accepts a stream of (destination, data) write requests over a valid/ready handshake and steers each into one of 16 held register slots. It buffers up to two requests and emits a one-cycle one-hot write strobe per committed write. It is the write-side counterpart of the 16:1 register read mux. Its slot outputs feed that mux's 16 inputs directly.

## Interface
- SIGNAL_WIDTH, default `REG_WIDTH (8): width of each data word and each register slot.
- SELECTOR_WIDTH, default 4: destination index width; fixed at 4 for 16 slots.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: write request present.
- in_sel, input, SELECTOR_WIDTH: destination slot index, 0..15.
- in_data, input, SIGNAL_WIDTH: data to write.
- in_ready, output, 1: block can accept a request this cycle.
- hold, input, 1: stall draining; buffered requests stay queued.
- bank_flat, output, 16*SIGNAL_WIDTH: slot i at [i*SIGNAL_WIDTH +: SIGNAL_WIDTH].
- wr_strobe, output, 16: one-hot pulse marking the slot written at the last edge.
- pending, output, 2: number of buffered requests, 0..2.

## Operation
- Request buffer:
  - 2-entry FIFO of {sel, data} with head pointer, tail pointer and 2-bit count.
  - in_ready = (count != 2). This is purely combinational from count; there is no same-cycle pass-through when full.
- Accept: a request is taken on an edge where in_valid && in_ready. It is written at the tail; tail toggles.
- Drain: on an edge where count != 0 && !hold:
  - the head entry pops and head toggles;
  - bank[head.sel] <= head.data;
  - wr_strobe <= one-hot(head.sel).
- At most one write per cycle. All other slots hold their value.
- Any edge with no drain: wr_strobe <= 0.
- Count update:
  - +1 on accept only;
  - −1 on drain only;
  - unchanged on simultaneous accept and drain, or neither.
- Ordering: strict FIFO. Back-to-back writes to the same slot commit in order; the last one wins.
- A request accepted at edge N is never drained at edge N. The earliest drain is edge N+1.
- hold never blocks accept while count < 2.
- in_sel and in_data are ignored when the request is not accepted.
- No state machine beyond the FIFO count: state is EMPTY (0), ONE (1), FULL (2).
  - EMPTY→ONE on accept.
  - ONE→FULL on accept without drain.
  - ONE→EMPTY on drain without accept.
  - FULL→ONE on drain. An accept is impossible in FULL.

## Timing
- Reset values (asserted asynchronously, held while rst_n = 0):
  - bank_flat = 0 for all slots;
  - wr_strobe = 0;
  - pending = 0;
  - FIFO pointers = 0;
  - in_ready = 1 once count = 0.
- Reset mid-operation: buffered requests are discarded, and the bank clears to 0 immediately without waiting for a clock edge.
- Release of rst_n: the first accept can occur at the first rising edge after deassertion.
- Latency: accept at edge N → slot value and wr_strobe both visible after edge N+1 when hold is low and the FIFO was empty.
- wr_strobe is registered and aligned with the bank update. Its high time is exactly one cycle per committed write; consecutive drains give consecutive pulses.
- Throughput: 1 write per cycle sustained with in_valid held high and hold low. pending then stays at 1.
- FULL with hold high: in_ready = 0. On the edge hold drops, one entry drains and in_ready returns to 1 in the following cycle.
- Simultaneous accept and drain at count = 1: the new entry is written at the tail and the old head commits, in the same edge.
- pending is the registered count. in_ready is derived from it with no extra delay.

## Test plan
- Reset: drive rst_n = 0 mid-stream with pending = 2 → bank_flat = 0, wr_strobe = 0 and pending = 0 immediately. in_ready = 1; no write commits after release.
- Single write: sel = 5, data = 8'hA7 accepted at edge N, hold = 0 → after N+1: slot 5 = 8'hA7, wr_strobe = 16'h0020 for one cycle, and all other slots = 0.
- Stream: 16 back-to-back requests, sel = i, data = 8'h10+i → slot i = 8'h10+i, one strobe per cycle in order 0..15, and pending = 1 throughout the stream.
- Hold/full: hold = 1, accept (3, 8'h11) then (3, 8'h22) → pending = 2, in_ready = 0, and a third request is not accepted. Release hold → slot 3 = 8'h11, then 8'h22 on the next edge.
- Same-slot ordering: (9, 8'hFF) then (9, 8'h00) back-to-back → final slot 9 = 8'h00 with two consecutive strobes of 16'h0200.
- Simultaneous: with pending = 1 and hold low, accept (15, 8'h5A) while the head drains → pending stays 1, and slot 15 = 8'h5A one edge later.
